one_sec_tick_gen: RTL and testbench

- Prescaler and run-control stage directly upstream of the countdown timer.
- Divides the system clock into a single-cycle one-second strobe, OneSecTimer, which drives the timer's decrement input.
- Starts on reconfig, can be paused, and stops permanently when the timer reports TimeOut.
- Keeps a saturating count of ticks issued since the last restart, for debug and display.

---
 rtl/one_sec_tick_gen.sv | 60 ++++++
 tb/tb_one_sec_tick_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/one_sec_tick_gen.sv
// one_sec_tick_gen: divides clk into a one-cycle OneSecTimer strobe with run/pause/stop control
// and a saturating count of strobes issued since the last reconfig.
module one_sec_tick_gen #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1,
    parameter int DIV_OVERRIDE = 0,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reconfig,
    input  logic       pause,
    input  logic       TimeOut,
    output logic       OneSecTimer,
    output logic       running,
    output logic [7:0] tick_count
);
    localparam int DIV = (DIV_OVERRIDE == 0) ? CLK_HZ / TICK_HZ : DIV_OVERRIDE;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3;

    if (DIV < 2) begin : g_bad_div
        $error("one_sec_tick_gen: DIV must be at least 2");
    end

    logic [1:0]       r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [7:0]       r_tc, w_tc;
    logic             r_tick, w_tick;
    logic             w_active, w_step, w_wrap;

    // RUN and PAUSED share transitions; leaving PAUSED counts that cycle so phase is kept
    always_comb begin
        w_active = (r_state == RUN) || (r_state == PAUSED);
        w_step   = w_active && !TimeOut && !pause;
        w_wrap   = w_step && (r_cnt == LAST);
        w_state  = reconfig ? RUN : !w_active ? r_state : TimeOut ? DONE : pause ? PAUSED : RUN;
        w_cnt    = (reconfig || w_wrap) ? '0 : w_step ? r_cnt + CNT_W'(1) : r_cnt;
        w_tc     = reconfig ? 8'd0 : (w_wrap && r_tc != 8'hFF) ? r_tc + 8'd1 : r_tc;
        w_tick   = !reconfig && w_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tc    <= 8'd0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_tc    <= w_tc;
            r_tick  <= w_tick;
        end
    end

    assign OneSecTimer = r_tick;
    assign running     = (r_state == RUN);
    assign tick_count  = r_tc;
endmodule

// File: tb/tb_one_sec_tick_gen.sv
// tb_one_sec_tick_gen: directed vector table plus reset, saturation and async-reset sequences,
// with DIV forced to 5.
module tb_one_sec_tick_gen;
    logic       clk = 0, rst = 0, reconfig = 0, pause = 0, TimeOut = 0;
    logic       OneSecTimer, running;
    logic [7:0] tick_count;
    int         errors = 0, checks = 0;

    typedef struct {
        logic       r, p, t, e_tick, e_run;
        logic [7:0] e_tc;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    one_sec_tick_gen #(.CLK_HZ(50000000), .TICK_HZ(1), .DIV_OVERRIDE(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .reconfig(reconfig), .pause(pause), .TimeOut(TimeOut),
        .OneSecTimer(OneSecTimer), .running(running), .tick_count(tick_count)
    );

    function automatic void add(logic r, logic p, logic t, logic e_tick, logic e_run, logic [7:0] e_tc);
        vecs.push_back('{r, p, t, e_tick, e_run, e_tc});
    endfunction

    task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic chk_all(string n, logic e_tick, logic e_run, logic [7:0] e_tc);
        chk({n, ".strobe"}, {7'd0, OneSecTimer}, {7'd0, e_tick});
        chk({n, ".running"}, {7'd0, running}, {7'd0, e_run});
        chk({n, ".tick_count"}, tick_count, e_tc);
    endtask

    initial begin
        int nstrb;
        // normal run: strobes after edges 5,10,...,25
        add(1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 26; k++) add(0, 0, 0, k % 5 == 0, 1, 8'(k / 5));
        // pause for 3 cycles at counter=2 delays second strobe to edge 13, then TimeOut at counter==4
        add(1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 0, k == 5, 1, k >= 5 ? 8'd1 : 8'd0);
        for (int k = 8; k <= 10; k++) add(0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 2);
        for (int k = 14; k <= 17; k++) add(0, 0, 0, 0, 1, 2);
        add(0, 0, 1, 0, 0, 2);
        for (int k = 0; k < 20; k++) add(0, k % 3 == 0, 0, 0, 0, 2);
        // restart from DONE
        add(1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 1);
        // reconfig held high: no strobes, counting starts once it drops
        for (int k = 0; k < 8; k++) add(1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1);
        // pause and TimeOut together go to DONE
        add(1, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 0, 0);

        // reset held, then idle with stray pause/TimeOut
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_all($sformatf("reset%0d", k), 0, 0, 0);
        end
        rst = 1;
        for (int k = 0; k < 20; k++) begin
            pause = (k % 4 == 1);
            TimeOut = (k % 5 == 2);
            @(negedge clk);
            chk_all($sformatf("idle%0d", k), 0, 0, 0);
        end
        pause = 0;
        TimeOut = 0;

        foreach (vecs[i]) begin
            reconfig = vecs[i].r;
            pause = vecs[i].p;
            TimeOut = vecs[i].t;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_run, vecs[i].e_tc);
        end

        // saturation: 300 strobes
        reconfig = 1;
        pause = 0;
        TimeOut = 0;
        @(negedge clk);
        reconfig = 0;
        nstrb = 0;
        for (int i = 1; i <= 1500; i++) begin
            @(negedge clk);
            if (OneSecTimer) nstrb++;
            if (i % 5 == 0) begin
                chk($sformatf("sat_strobe%0d", i), {7'd0, OneSecTimer}, 8'd1);
                chk($sformatf("sat_tc%0d", i), tick_count, (i / 5 > 255) ? 8'd255 : 8'(i / 5));
            end
        end
        chk("sat_count", 8'(nstrb == 300), 8'd1);

        // async reset while strobe is high, between clock edges
        #1 rst = 0;
        #1;
        chk_all("async_rst", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_all($sformatf("post_rst%0d", k), 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
